// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARMv4 control unit: FSM states, datapath
// mux selects, ALU operations, instruction classes and condition codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_check.sv
// ARM conditional-execution evaluator: decides from the condition field and the
// stored NZCV flags whether the current instruction may commit its effects.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        condex = 1'b0;
        case (cond)
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            COND_NV: condex = 1'b0;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle ARMv4 core: sequences the shared ALU and the
// unified memory, owns the NZCV flags and gates all writes on the condition.
module multicycle_control_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite
);

    state_t     state_q;
    logic [3:0] flags_q;
    logic       condex_q;
    logic       condex;

    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       ir_write;
    logic [1:0] flag_w;
    logic       rd_is_pc;
    logic       pcs;
    logic       in_exec;

    cond_check u_cond_check (
        .cond   (Cond),
        .flags  (flags_q),
        .condex (condex)
    );

    assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

    // NOTE: all state in this block uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_DP:   state_q <= Funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_q <= S_MEMADR;
                        OP_BR:   state_q <= S_BRANCH;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXECR,
                S_EXECI:  state_q <= S_ALUWB;
                default:  state_q <= S_FETCH;
            endcase

            // The condition is frozen here so flag writes in EXEC cannot change it mid-instruction.
            if (state_q == S_DECODE) begin
                condex_q <= condex;
            end

            if (in_exec && condex_q) begin
                if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_pc   = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        ir_write  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_EXTIMM;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR: begin
                ALUSrcB = SRCB_RD2;
                alu_op  = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB = SRCB_EXTIMM;
                alu_op  = 1'b1;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Unrecognised commands fall back to ADD and never touch the flags.
    always_comb begin
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        if (alu_op) begin
            case (Funct[4:1])
                CMD_ADD: begin
                    ALUControl = ALU_ADD;
                    flag_w     = {Funct[0], Funct[0]};
                end
                CMD_SUB: begin
                    ALUControl = ALU_SUB;
                    flag_w     = {Funct[0], Funct[0]};
                end
                CMD_AND: begin
                    ALUControl = ALU_AND;
                    flag_w     = {Funct[0], 1'b0};
                end
                CMD_ORR: begin
                    ALUControl = ALU_ORR;
                    flag_w     = {Funct[0], 1'b0};
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (Op)
            OP_DP:   ImmSrc = IMM_8;
            OP_MEM:  ImmSrc = IMM_12;
            OP_BR:   ImmSrc = IMM_24;
            default: ImmSrc = IMM_8;
        endcase
    end

    assign RegSrc = {(Op == OP_MEM) && !Funct[0], (Op == OP_BR)};

    // Writes to R15 are steered to the PC enable, never to the register file.
    assign rd_is_pc = (Rd == 4'hF);
    assign pcs      = (rd_is_pc & reg_w) | branch;

    assign PCWrite  = ~reset & (next_pc | (pcs & condex_q));
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_w & condex_q & ~rd_is_pc;
    assign MemWrite = ~reset & mem_w & condex_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: a table of instructions with
// expected latency and write strobes, reset-abort sequences, and random traffic.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] mflags;

    multicycle_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        int         len;
        logic [7:0] pcw;
        logic [7:0] regw;
        logic [7:0] memw;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ARM conditions come in complementary pairs: bits [3:1] pick a test, bit 0 inverts it.
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic int model_len(input logic [1:0] o, input logic [5:0] f);
        case (o)
            2'b00:   return 4;
            2'b01:   return f[0] ? 5 : 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 2'b00;
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Expected output word for cycle k of an instruction (cycle 0 is the fetch).
    function automatic logic [15:0] model(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                                          input int k, input logic ex);
        logic       pcw, adr, memw, irw, asa, regw;
        logic [1:0] res, alu, asb, imm, rsrc;
        pcw = 0; adr = 0; memw = 0; irw = 0; asa = 0; regw = 0;
        res = 2'b00; alu = 2'b00; asb = 2'b00;
        imm  = (o == 2'b11) ? 2'b00 : o;
        rsrc = {(o == 2'b01) && !f[0], o == 2'b10};
        if (k >= model_len(o, f)) return 16'hFFFF;
        if (k == 0) begin
            irw = 1; pcw = 1; asa = 1; asb = 2'b10; res = 2'b10;
        end else if (k == 1) begin
            asa = 1; asb = 2'b10; res = 2'b10;
        end else begin
            case (o)
                2'b00: begin
                    if (k == 2) begin
                        asb = f[5] ? 2'b01 : 2'b00;
                        alu = alu_of(f[4:1]);
                    end else begin
                        regw = ex && (r != 4'hF);
                        pcw  = ex && (r == 4'hF);
                    end
                end
                2'b01: begin
                    if (k == 2) asb = 2'b01;
                    else if (k == 3) begin
                        adr  = 1;
                        memw = ex && !f[0];
                    end else begin
                        res  = 2'b01;
                        regw = ex && (r != 4'hF);
                        pcw  = ex && (r == 4'hF);
                    end
                end
                2'b10: begin
                    asb = 2'b01; res = 2'b10; pcw = ex;
                end
                default: begin
                end
            endcase
        end
        return {pcw, adr, memw, irw, res, alu, asa, asb, imm, rsrc, regw};
    endfunction

    function automatic logic [15:0] observed();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA, ALUSrcB,
                ImmSrc, RegSrc, RegWrite};
    endfunction

    function automatic logic [3:0] next_flags(input logic [3:0] fl, input logic [1:0] o, input logic [5:0] f,
                                              input logic [3:0] af, input logic ex);
        logic [3:0] nf;
        nf = fl;
        if (o == 2'b00 && ex && f[0]) begin
            case (f[4:1])
                4'b0100, 4'b0010: nf = af;
                4'b0000, 4'b1100: nf[3:2] = af[3:2];
                default: begin
                end
            endcase
        end
        return nf;
    endfunction

    // Called positioned in a FETCH cycle; returns positioned in the next FETCH.
    task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af,
                             output int len, output logic [7:0] pcw, output logic [7:0] regw,
                             output logic [7:0] memw);
        logic ex;
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
        ex   = cond_holds(c, mflags);
        len  = 0; pcw = '0; regw = '0; memw = '0;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0 && IRWrite === 1'b1) begin
                len = k;
                break;
            end
            check($sformatf("%s cyc%0d outputs", name, k), 32'(observed()), 32'(model(o, f, r, k, ex)));
            pcw[k]  = PCWrite;
            regw[k] = RegWrite;
            memw[k] = MemWrite;
            @(negedge clk); #1;
        end
        check($sformatf("%s latency", name), 32'(len), 32'(model_len(o, f)));
        if (len == 0) begin
            $display("FAIL %s: no refetch within cycle budget", name);
            $fatal(1, "instruction never completed");
        end
        mflags = next_flags(mflags, o, f, af, ex);
    endtask

    // Abort an instruction by asserting reset during its cycle 'at'.
    task automatic reset_abort(input string name, input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                               input logic [3:0] r, input logic [3:0] af, input int at);
        logic ex;
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
        ex   = cond_holds(c, mflags);
        #1;
        for (int k = 0; k < at; k++) begin
            check($sformatf("%s cyc%0d outputs", name, k), 32'(observed()), 32'(model(o, f, r, k, ex)));
            @(negedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check($sformatf("%s writes during reset", name), {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mflags = 4'b0000;
        #1;
        check($sformatf("%s refetch after reset", name), 32'(IRWrite), 32'd1);
    endtask

    initial begin
        int         len;
        logic [7:0] pcw, regw, memw;

        tbl[0]  = '{"ADD r1",    4'hE, 2'b00, 6'b001000, 4'h1, 4'b0000, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[1]  = '{"SUBS z",    4'hE, 2'b00, 6'b100101, 4'h0, 4'b0100, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[2]  = '{"BEQ taken", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 3, 8'b0101,  8'b0,     8'b0};
        tbl[3]  = '{"SUBS nz",   4'hE, 2'b00, 6'b100101, 4'h0, 4'b0010, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[4]  = '{"BEQ not",   4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 3, 8'b0001,  8'b0,     8'b0};
        tbl[5]  = '{"LDR r2",    4'hE, 2'b01, 6'b011001, 4'h2, 4'b0000, 5, 8'b00001, 8'b10000, 8'b0};
        tbl[6]  = '{"STR r2",    4'hE, 2'b01, 6'b011000, 4'h2, 4'b0000, 4, 8'b0001,  8'b0,     8'b1000};
        tbl[7]  = '{"ADD r15",   4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 4, 8'b1001,  8'b0,     8'b0};
        tbl[8]  = '{"NOP op11",  4'hE, 2'b11, 6'b000000, 4'h0, 4'b0000, 2, 8'b01,    8'b0,     8'b0};
        tbl[9]  = '{"ADDNE",     4'h1, 2'b00, 6'b001000, 4'h3, 4'b0000, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[10] = '{"ANDS",      4'hE, 2'b00, 6'b000001, 4'h4, 4'b1011, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[11] = '{"ADDMI",     4'h4, 2'b00, 6'b001000, 4'h5, 4'b0000, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[12] = '{"ADDPL",     4'h5, 2'b00, 6'b001000, 4'h5, 4'b0000, 4, 8'b0001,  8'b0,     8'b0};
        tbl[13] = '{"ORRS",      4'hE, 2'b00, 6'b011001, 4'h6, 4'b0111, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[14] = '{"BEQ z1",    4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 3, 8'b0101,  8'b0,     8'b0};
        tbl[15] = '{"STRNE",     4'h1, 2'b01, 6'b011000, 4'h2, 4'b0000, 4, 8'b0001,  8'b0,     8'b0};
        tbl[16] = '{"EORS",      4'hE, 2'b00, 6'b000011, 4'h7, 4'b1111, 4, 8'b0001,  8'b1000,  8'b0};
        tbl[17] = '{"BEQ keep",  4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 3, 8'b0101,  8'b0,     8'b0};
        tbl[18] = '{"LDR r15",   4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000, 5, 8'b10001, 8'b0,     8'b0};

        reset = 1'b1; Cond = 4'h0; Op = 2'b00; Funct = 6'd0; Rd = 4'h0; ALUFlags = 4'h0;
        mflags = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check("writes held off in reset", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_instr(tbl[i].name, tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].af,
                      len, pcw, regw, memw);
            check({tbl[i].name, " len"},  32'(len),  32'(tbl[i].len));
            check({tbl[i].name, " pcw"},  32'(pcw),  32'(tbl[i].pcw));
            check({tbl[i].name, " regw"}, 32'(regw), 32'(tbl[i].regw));
            check({tbl[i].name, " memw"}, 32'(memw), 32'(tbl[i].memw));
        end

        // Reset in MEMRD after Z was set: flags must be cleared, so BEQ falls through.
        run_instr("pre SUBS", 4'hE, 2'b00, 6'b100101, 4'h0, 4'b0100, len, pcw, regw, memw);
        reset_abort("abort LDR memrd", 4'hE, 2'b01, 6'b011001, 4'h2, 4'b0000, 3);
        run_instr("BEQ after abort", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, len, pcw, regw, memw);
        check("BEQ after abort pcw", 32'(pcw), 32'h1);

        reset_abort("abort STR memwr", 4'hE, 2'b01, 6'b011000, 4'h2, 4'b0000, 3);
        reset_abort("abort SUBS execi", 4'hE, 2'b00, 6'b100101, 4'h0, 4'b0100, 2);
        run_instr("BEQ after execi abort", 4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, len, pcw, regw, memw);
        check("BEQ after execi abort pcw", 32'(pcw), 32'h1);
        reset_abort("abort ADD aluwb", 4'hE, 2'b00, 6'b001000, 4'h1, 4'b0000, 3);
        reset_abort("abort ADD r15 aluwb", 4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, 3);

        for (int i = 0; i < 300; i++) begin
            run_instr($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      len, pcw, regw, memw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
